// File: rtl/hamming_rx_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) decoder across NUM_CH receiver channels.
// Optional build macro HAMMING_CORRECT_EN enables single-bit correction of the data nibble.
module hamming_rx_arbiter #(
  parameter int unsigned NUM_CH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [NUM_CH*7-1:0] ch_data,
  input  logic [NUM_CH-1:0]   ch_valid,
  output logic [3:0]          out_data,
  output logic [1:0]          out_chan,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_CH-1:0]   overrun,
  input  logic                overrun_clr
);

  localparam int unsigned CW_W   = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH-1:0][CW_W-1:0] hold;
  logic [NUM_CH-1:0]           pending;
  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            gnt;
  logic [CW_W-1:0]             cw;

  logic [NUM_CH-1:0]           rot_c;
  logic [IDX_W-1:0]            gnt_sel_c;
  logic [CW_W-1:0]             hold_sel_c;
  logic [NUM_CH-1:0]           ovr_set_c;
  logic [2:0]                  syn_c;
  logic [DATA_W-1:0]           data_c;
  logic                        grant_c;
  logic                        load_c;
  logic                        done_c;

  // First pending channel at or above rr_ptr, with wrap
  always_comb begin
    rot_c     = NUM_CH'({pending, pending} >> rr_ptr);
    gnt_sel_c = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot_c[k]) gnt_sel_c = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_CH);
    end
  end

  always_comb begin
    hold_sel_c = '0;
    ovr_set_c  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_sel_c == IDX_W'(i)) hold_sel_c = hold[i];
      // A frame arriving on the channel being granted this cycle refills the slot instead of dropping
      ovr_set_c[i] = ch_valid[i] && pending[i] && !(grant_c && gnt_sel_c == IDX_W'(i));
    end
  end

  always_comb begin
    syn_c = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
             cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
             cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
`ifdef HAMMING_CORRECT_EN
    // Only syndromes pointing at data positions 3,5,6,7 change the nibble
    data_c = {cw[6], cw[5], cw[4], cw[2]} ^
             {syn_c == 3'd7, syn_c == 3'd6, syn_c == 3'd5, syn_c == 3'd3};
`else
    data_c = {cw[6], cw[5], cw[4], cw[2]};
`endif
  end

  always_comb begin
    state_nxt = state;
    grant_c   = 1'b0;
    load_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant_c   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        load_c    = 1'b1;
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      gnt       <= '0;
      cw        <= '0;
      overrun   <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (ena) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i] && !ovr_set_c[i]) begin
          hold[i]    <= ch_data[CW_W*i +: CW_W];
          pending[i] <= 1'b1;
        end else if (grant_c && gnt_sel_c == IDX_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
      overrun <= (overrun & ~{NUM_CH{overrun_clr}}) | ovr_set_c;
      if (grant_c) begin
        gnt <= gnt_sel_c;
        cw  <= hold_sel_c;
      end
      if (load_c) begin
        out_data  <= data_c;
        out_chan  <= gnt;
        out_err   <= |syn_c;
        out_valid <= 1'b1;
      end
      if (done_c) begin
        out_valid <= 1'b0;
        rr_ptr    <= (gnt == IDX_W'(NUM_CH - 1)) ? '0 : gnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_rx_arbiter.sv
// Scoreboard bench for hamming_rx_arbiter: directed frames, expected words queued, monitor checks on handshake.
module tb_hamming_rx_arbiter;

  localparam int unsigned NUM_CH = 2;

  logic                clk;
  logic                rst;
  logic                ena;
  logic [NUM_CH*7-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_valid;
  logic [3:0]          out_data;
  logic [1:0]          out_chan;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_CH-1:0]   overrun;
  logic                overrun_clr;

  // Valid codewords, written {c6..c0}
  localparam logic [6:0] CW_A = 7'b1010101;  // data 1011
  localparam logic [6:0] CW_B = 7'b0110011;  // data 0110
  localparam logic [6:0] CW_C = 7'b0000111;  // data 0001
  localparam logic [6:0] CW_D = 7'b1111111;  // data 1111
  localparam logic [6:0] CW_E = 7'b1000101;  // CW_A with c4 flipped, syndrome 5
`ifdef HAMMING_CORRECT_EN
  localparam logic [3:0] ERR_DATA = 4'b1011;
`else
  localparam logic [3:0] ERR_DATA = 4'b1001;
`endif

  typedef struct packed {
    logic       err;
    logic [1:0] chan;
    logic [3:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hamming_rx_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Handshake monitor: a transfer completes on the next rising edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ena && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", {out_err, out_chan, out_data});
      end else begin
        e = exp_q.pop_front();
        check("out_word", {25'd0, out_err, out_chan, out_data}, {25'd0, e});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] vmask, input logic [6:0] cw0, input logic [6:0] cw1);
    ch_data  = {cw1, cw0};
    ch_valid = vmask;
    tick(1);
    ch_valid = '0;
  endtask

  task automatic expect_word(input logic [3:0] d, input logic [1:0] c, input logic e);
    exp_q.push_back({e, c, d});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick(2);
  endtask

  initial begin
    rst         = 1'b1;
    ena         = 1'b1;
    ch_data     = '0;
    ch_valid    = '0;
    out_ready   = 1'b1;
    overrun_clr = 1'b0;
    tick(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_chan", 32'(out_chan), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick(1);

    // Clean frame and latency
    expect_word(4'b1011, 2'd0, 1'b0);
    pulse(2'b01, CW_A, 7'd0);
    check("lat_e0", 32'(out_valid), 32'd0);
    tick(1);
    check("lat_e1", 32'(out_valid), 32'd0);
    tick(1);
    check("lat_e2", 32'(out_valid), 32'd1);
    tick(1);
    check("valid_one_cycle", 32'(out_valid), 32'd0);
    tick(2);

    // Single-bit error on ch1
    expect_word(ERR_DATA, 2'd1, 1'b1);
    pulse(2'b10, 7'd0, CW_E);
    drain();

    // Round-robin from rr_ptr=0, twice
    expect_word(4'b1011, 2'd0, 1'b0);
    expect_word(4'b0110, 2'd1, 1'b0);
    pulse(2'b11, CW_A, CW_B);
    drain();
    expect_word(4'b0001, 2'd0, 1'b0);
    expect_word(4'b1111, 2'd1, 1'b0);
    pulse(2'b11, CW_C, CW_D);
    drain();

    // After serving ch0 alone, ch1 wins the next contention
    expect_word(4'b0001, 2'd0, 1'b0);
    pulse(2'b01, CW_C, 7'd0);
    drain();
    expect_word(4'b0110, 2'd1, 1'b0);
    expect_word(4'b1011, 2'd0, 1'b0);
    pulse(2'b11, CW_A, CW_B);
    drain();

    // Backpressure: A held, B captured, C dropped
    out_ready = 1'b0;
    expect_word(4'b1011, 2'd0, 1'b0);
    expect_word(4'b0110, 2'd0, 1'b0);
    pulse(2'b01, CW_A, 7'd0);
    tick(1);
    pulse(2'b01, CW_B, 7'd0);
    tick(1);
    pulse(2'b01, CW_C, 7'd0);
    check("bp_overrun_set", 32'(overrun), 32'd1);
    check("bp_valid", 32'(out_valid), 32'd1);
    tick(3);
    check("bp_hold_data", 32'(out_data), 32'hb);
    check("bp_hold_chan", 32'(out_chan), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain();
    check("overrun_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);

    // Freeze during OUTPUT
    out_ready = 1'b0;
    expect_word(4'b1111, 2'd0, 1'b0);
    pulse(2'b01, CW_D, 7'd0);
    tick(2);
    check("frz_pre_valid", 32'(out_valid), 32'd1);
    ena       = 1'b0;
    out_ready = 1'b1;
    pulse(2'b10, 7'd0, CW_B);
    tick(9);
    check("frz_valid", 32'(out_valid), 32'd1);
    check("frz_data", 32'(out_data), 32'hf);
    check("frz_overrun", 32'(overrun), 32'd0);
    ena = 1'b1;
    drain();
    tick(6);
    check("frz_no_capture", 32'(out_valid), 32'd0);

    // Reset while in DECODE with another frame pending and an overrun flagged
    out_ready = 1'b1;
    pulse(2'b11, CW_A, CW_B);
    pulse(2'b01, CW_C, 7'd0);
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    tick(8);
    check("mid_rst_quiet", 32'(out_valid), 32'd0);
    expect_word(4'b1111, 2'd1, 1'b0);
    pulse(2'b10, 7'd0, CW_D);
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
